// File: rtl/solver_pkg.sv
// ---------------------------------------------------------------------------
// solver_pkg
// Shared types and constants for the solver scheduler slice.
//   OP_W      : width of one operand vector {a,b,c,d,e}
//   MAX_NREQ  : largest supported requester count
//   ID_W      : tag id width, wide enough for any supported requester count
//   CNT_W     : width of the per-requester in-flight counters
//   operand_t : one operand vector, a is the MSB
//   tag_t     : per-stage tag travelling alongside the solver pipeline
// ---------------------------------------------------------------------------
package solver_pkg;

   localparam int OP_W     = 5;
   localparam int MAX_NREQ = 8;
   localparam int ID_W     = $clog2(MAX_NREQ);
   localparam int CNT_W    = 3;

   typedef struct packed {
      logic a;
      logic b;
      logic c;
      logic d;
      logic e;
   } operand_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/solver_sched_if.sv
// ---------------------------------------------------------------------------
// solver_sched_if
// Requester and response handshake bundle of the solver scheduler.
//   req_valid  : requester i has an operand vector
//   req_data   : vector i at bits [5i+4:5i], order {a,b,c,d,e}
//   req_ready  : one-hot grant from the scheduler
//   resp_valid : result available
//   resp_id    : originating requester of the result
//   resp_f     : solver result
//   resp_ready : consumer accepts the result
// Modports: master = requesters/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface solver_sched_if
   import solver_pkg::*;
#(
   parameter int NREQ = 4
);

   logic [NREQ-1:0]         req_valid;
   logic [OP_W*NREQ-1:0]    req_data;
   logic [NREQ-1:0]         req_ready;
   logic                    resp_valid;
   logic [$clog2(NREQ)-1:0] resp_id;
   logic                    resp_f;
   logic                    resp_ready;

   modport master (
      output req_valid,
      output req_data,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_id,
      input  resp_f
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_id,
      output resp_f
   );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The winner is the first requesting
// index after last_grant, wrapping modulo NREQ.
//   req        : in  NREQ        candidate vector
//   enable     : in  1           when low no grant is issued
//   last_grant : in  clog2(NREQ) index granted most recently
//   grant      : out NREQ        one-hot grant
//   grant_idx  : out clog2(NREQ) encoded winner (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic                    enable,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NREQ);

   logic             found;
   logic [IDX_W-1:0] idx;

   // Walk the requesters starting just after last_grant; k = NREQ revisits
   // last_grant itself so a lone requester can be granted repeatedly.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDX_W'((int'(last_grant) + k) % NREQ);
         if (enable && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/solver_sched.sv
// ---------------------------------------------------------------------------
// solver_sched
// Shares one pipelined solver among NREQ requesters. One operand vector is
// granted per cycle round-robin, registered onto sol_a..sol_e, and tagged
// with its requester id. The tag travels alongside the solver pipeline and
// reappears with sol_f as the response. A stalled response freezes the whole
// pipeline, including the solver via sol_load.
//   clock       : in  single clock, rising edge
//   clear_n     : in  synchronous active-low reset
//   bus         : slave side of solver_sched_if (requests and responses)
//   sol_a..e    : out operand bits to the solver
//   sol_f       : in  solver result
//   sol_load    : out solver load/advance enable
//   sol_clear   : out solver clear, active-high, follows clear_n directly
// ---------------------------------------------------------------------------
module solver_sched
   import solver_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int SOLVER_DEPTH = 2,
   parameter int MAX_OUT      = 2
) (
   input  logic          clock,
   input  logic          clear_n,
   solver_sched_if.slave bus,
   output logic          sol_a,
   output logic          sol_b,
   output logic          sol_c,
   output logic          sol_d,
   output logic          sol_e,
   input  logic          sol_f,
   output logic          sol_load,
   output logic          sol_clear
);

   localparam int               RID_W   = $clog2(NREQ);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   operand_t         op_reg;
   operand_t         win_op;
   tag_t             tag_pipe [SOLVER_DEPTH+1];
   logic [CNT_W-1:0] outstanding [NREQ];
   logic [RID_W-1:0] last_grant;
   logic [NREQ-1:0]  candidates;
   logic [NREQ-1:0]  grant;
   logic [RID_W-1:0] grant_idx;
   logic             advance;
   logic             arb_en;
   logic             resp_hs;

   // A result that is offered but not taken holds every stage in place.
   assign advance   = !(bus.resp_valid && !bus.resp_ready);
   assign resp_hs   = bus.resp_valid && bus.resp_ready;
   assign arb_en    = advance && clear_n;
   assign sol_load  = advance;
   assign sol_clear = !clear_n;

   // Requesters that already have MAX_OUT vectors in flight sit out.
   always_comb begin
      candidates = '0;
      for (int i = 0; i < NREQ; i++) begin
         candidates[i] = bus.req_valid[i] && (outstanding[i] < MAX_CNT);
      end
   end

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arbiter (
      .req        (candidates),
      .enable     (arb_en),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign bus.req_ready = grant;

   // Select the winning operand vector with the one-hot grant.
   always_comb begin
      win_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_op = operand_t'(bus.req_data[OP_W*i +: OP_W]);
         end
      end
   end

   // Operand register, tag pipe and arbitration pointer. Without an accept
   // the operands keep their old value and a bubble enters stage 0.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         op_reg     <= '0;
         last_grant <= RID_W'(NREQ - 1);
         for (int k = 0; k <= SOLVER_DEPTH; k++) begin
            tag_pipe[k] <= '0;
         end
      end else if (advance) begin
         if (|grant) begin
            op_reg      <= win_op;
            tag_pipe[0] <= '{valid: 1'b1, id: ID_W'(grant_idx)};
            last_grant  <= grant_idx;
         end else begin
            tag_pipe[0] <= '0;
         end
         for (int k = 1; k <= SOLVER_DEPTH; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
         end
      end
   end

   // In-flight counters. Candidates are already capped at MAX_OUT and the
   // decrement is guarded, so the counter can neither overflow nor wrap.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         for (int i = 0; i < NREQ; i++) begin
            outstanding[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant[i] && !(resp_hs && tag_pipe[SOLVER_DEPTH].id == ID_W'(i))
                && outstanding[i] < MAX_CNT) begin
               outstanding[i] <= outstanding[i] + 1'b1;
            end else if (!grant[i] && resp_hs && tag_pipe[SOLVER_DEPTH].id == ID_W'(i)
                         && outstanding[i] != '0) begin
               outstanding[i] <= outstanding[i] - 1'b1;
            end
         end
      end
   end

   assign sol_a = op_reg.a;
   assign sol_b = op_reg.b;
   assign sol_c = op_reg.c;
   assign sol_d = op_reg.d;
   assign sol_e = op_reg.e;

   assign bus.resp_valid = tag_pipe[SOLVER_DEPTH].valid;
   assign bus.resp_id    = tag_pipe[SOLVER_DEPTH].id[RID_W-1:0];
   assign bus.resp_f     = sol_f;

endmodule
